// File: rtl/pe_acc_v2_if.sv
// Preload and writeback handshake bundle between a PE and its row/column controller.
interface pe_acc_v2_if #(parameter int ACC_W = 32);
  logic [ACC_W-1:0] load_data;
  logic             load_vld;
  logic             load_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (output load_data, load_vld, out_ready,
                  input  load_ready, out_data, out_valid, out_last);
  modport slave  (input  load_data, load_vld, out_ready,
                  output load_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/pe_acc_v2.sv
// Multi-lane INT16/INT8/INT4 dot-product PE with a DEPTH-entry accumulator bank.
// Optional macro PE_ACC_SAT_EN: saturating accumulation plus a sticky sat_flag port.
module pe_acc_v2_lane #(parameter int W = 8) (
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic                  sgn,
  output logic signed [2*W+1:0] prod
);
  logic signed [2*W+1:0] ae, be;
  assign ae   = {{(W+2){sgn & a[W-1]}}, a};
  assign be   = {{(W+2){sgn & b[W-1]}}, b};
  assign prod = ae * be;
endmodule

module pe_acc_v2 #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_left,
  input  logic              a_left_vld,
  input  logic [1:0]        mode_left,
  input  logic              sgn_left,
  output logic [DATA_W-1:0] a_right,
  output logic              a_right_vld,
  output logic [1:0]        mode_right,
  output logic              sgn_right,
  input  logic [DATA_W-1:0] b_up,
  input  logic              b_up_vld,
  output logic [DATA_W-1:0] b_down,
  output logic              b_down_vld,
  input  logic              start,
  input  logic              drain,
  pe_acc_v2_if.slave        wb,
  output logic              busy,
`ifdef PE_ACC_SAT_EN
  output logic              sat_flag,
`endif
  output logic              err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int N16   = DATA_W / 16;
  localparam int N8    = DATA_W / 8;
  localparam int N4    = DATA_W / 4;
  localparam int SUM_W = 2 * DATA_W + 2;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t                        state;
  logic [PTR_W-1:0]              ptr, ptr_inc;
  logic [DEPTH-1:0][ACC_W-1:0]   acc;
  logic [ACC_W-1:0]              acc_cur, acc_nxt;
  logic                          ld_rdy, out_vld, out_lst;
  logic                          beat, ld_acc, mode_ok;

  logic [N16-1:0][2*16+1:0]      p16;
  logic [N8-1:0][2*8+1:0]        p8;
  logic [N4-1:0][2*4+1:0]        p4;
  logic signed [SUM_W-1:0]       s16, s8, s4, sum;

  // One multiplier array per lane mode; the mode only picks which sum is used.
  for (genvar i = 0; i < N16; i++) begin : g16
    pe_acc_v2_lane #(.W(16)) u_lane (.a(a_left[i*16 +: 16]), .b(b_up[i*16 +: 16]),
                                     .sgn(sgn_left), .prod(p16[i]));
  end
  for (genvar i = 0; i < N8; i++) begin : g8
    pe_acc_v2_lane #(.W(8)) u_lane (.a(a_left[i*8 +: 8]), .b(b_up[i*8 +: 8]),
                                    .sgn(sgn_left), .prod(p8[i]));
  end
  for (genvar i = 0; i < N4; i++) begin : g4
    pe_acc_v2_lane #(.W(4)) u_lane (.a(a_left[i*4 +: 4]), .b(b_up[i*4 +: 4]),
                                    .sgn(sgn_left), .prod(p4[i]));
  end

  always_comb begin
    s16 = '0;
    s8  = '0;
    s4  = '0;
    for (int i = 0; i < N16; i++) s16 = s16 + SUM_W'($signed(p16[i]));
    for (int i = 0; i < N8;  i++) s8  = s8  + SUM_W'($signed(p8[i]));
    for (int i = 0; i < N4;  i++) s4  = s4  + SUM_W'($signed(p4[i]));
    case (mode_left)
      2'b00:   sum = s16;
      2'b01:   sum = s8;
      2'b10:   sum = s4;
      default: sum = '0;
    endcase
  end

  assign beat    = a_left_vld & b_up_vld;
  assign mode_ok = (mode_left != 2'b11);
  assign ld_acc  = wb.load_vld & ld_rdy;
  assign ptr_inc = ptr + 1'b1;
  assign acc_cur = acc[ptr];

`ifdef PE_ACC_SAT_EN
  localparam int EXT_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 2;
  localparam logic signed [EXT_W-1:0] SMAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SMIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] UMAX = {{(EXT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
  logic signed [EXT_W-1:0] acc_ext, tot;
  logic                    clamp;

  // Exact sum in a wide domain, then clamp to the signed or unsigned ACC_W range.
  always_comb begin
    clamp = 1'b0;
    if (sgn_left) acc_ext = EXT_W'($signed(acc_cur));
    else          acc_ext = EXT_W'({1'b0, acc_cur});
    tot     = acc_ext + EXT_W'(sum);
    acc_nxt = tot[ACC_W-1:0];
    if (sgn_left) begin
      if (tot > SMAX)      begin acc_nxt = SMAX[ACC_W-1:0]; clamp = 1'b1; end
      else if (tot < SMIN) begin acc_nxt = SMIN[ACC_W-1:0]; clamp = 1'b1; end
    end else begin
      if (tot > UMAX)      begin acc_nxt = UMAX[ACC_W-1:0]; clamp = 1'b1; end
      else if (tot < 0)    begin acc_nxt = '0;              clamp = 1'b1; end
    end
  end
`else
  assign acc_nxt = acc_cur + ACC_W'(sum);
`endif

  assign wb.load_ready = ld_rdy;
  assign wb.out_valid  = out_vld;
  assign wb.out_last   = out_lst;
  assign wb.out_data   = out_vld ? acc_cur : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      acc         <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      ld_rdy      <= 1'b0;
      out_vld     <= 1'b0;
      out_lst     <= 1'b0;
      a_right     <= '0;
      a_right_vld <= 1'b0;
      mode_right  <= '0;
      sgn_right   <= 1'b0;
      b_down      <= '0;
      b_down_vld  <= 1'b0;
`ifdef PE_ACC_SAT_EN
      sat_flag    <= 1'b0;
`endif
    end else begin
      a_right     <= a_left;
      a_right_vld <= a_left_vld;
      mode_right  <= mode_left;
      sgn_right   <= sgn_left;
      b_down      <= b_up;
      b_down_vld  <= b_up_vld;

      if ((beat && (state != COMPUTE || !mode_ok)) || (start && state != IDLE) ||
          (drain && state != COMPUTE) || (wb.load_vld && !ld_rdy))
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (ld_acc) begin
            acc[0] <= wb.load_data;
            ptr    <= PTR_W'(1);
            state  <= LOAD;
            busy   <= 1'b1;
            if (start) err <= 1'b1;
          end else if (start) begin
            acc    <= '0;
            ptr    <= '0;
            state  <= COMPUTE;
            busy   <= 1'b1;
            ld_rdy <= 1'b0;
`ifdef PE_ACC_SAT_EN
            sat_flag <= 1'b0;
`endif
          end else begin
            ld_rdy <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_acc) begin
            acc[ptr] <= wb.load_data;
            ptr      <= ptr_inc;
            if (ptr == PTR_MAX) begin
              state  <= COMPUTE;
              ld_rdy <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          if (beat) begin
            if (mode_ok) begin
              acc[ptr] <= acc_nxt;
`ifdef PE_ACC_SAT_EN
              if (clamp) sat_flag <= 1'b1;
`endif
            end
            ptr <= ptr_inc;
          end
          // Same-cycle beat lands at the old ptr; the reset of ptr below wins.
          if (drain) begin
            state   <= DRAIN;
            ptr     <= '0;
            out_vld <= 1'b1;
            out_lst <= 1'b0;
          end
        end
        DRAIN: begin
          if (wb.out_ready) begin
            ptr     <= ptr_inc;
            out_lst <= (ptr_inc == PTR_MAX);
            if (out_lst) begin
              state   <= IDLE;
              ptr     <= '0;
              out_vld <= 1'b0;
              out_lst <= 1'b0;
              busy    <= 1'b0;
              ld_rdy  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pe_acc_v2.md
Name: pe_acc_v2

Overview:
- Parametrised successor PE for the systolic tensor-core array: integer multi-lane dot-product MAC with a DEPTH-entry accumulator bank.
- Forwards operands right/down with one-cycle registered skew.
- Explicit IDLE/LOAD/COMPUTE/DRAIN state machine; valid/ready writeback replaces the ad-hoc we/wben control.
- Sits in the PE grid; the row/column controller drives start/load/drain.

Parameters:
DATA_W, 32, operand width; must be a multiple of 16.
ACC_W, 32, accumulator entry and writeback width.
DEPTH, 4, accumulator entries; a power of two, at least 2. Pointer width is the localparam PTR_W = $clog2(DEPTH).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-low.
a_left  in  DATA_W  row operand.
a_left_vld  in  1  row operand valid.
mode_left  in  2  lane mode that travels with a: 00 = INT16 (DATA_W/16 lanes), 01 = INT8 (DATA_W/8 lanes), 10 = INT4 (DATA_W/4 lanes), 11 = reserved.
sgn_left  in  1  signed operands when 1.
a_right, a_right_vld, mode_right, sgn_right  out  DATA_W/1/2/1  registered forward of the four row inputs.
b_up  in  DATA_W  column operand.
b_up_vld  in  1  column operand valid.
b_down, b_down_vld  out  DATA_W/1  registered forward of the column inputs.
start  in  1  IDLE only: zero all entries, enter COMPUTE.
load_data  in  ACC_W  accumulator preload value.
load_vld  in  1  preload beat valid.
load_ready  out  1  preload beat accepted.
drain  in  1  COMPUTE only: request writeback.
out_data  out  ACC_W  writeback data.
out_valid  out  1  writeback valid.
out_ready  in  1  writeback ready.
out_last  out  1  marks the final writeback beat.
busy  out  1  high whenever state is not IDLE.
err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, async): state=IDLE, ptr=0, all acc entries=0, every output=0.
- Forwarding: every *_right/*_down output is registered from its input each cycle, in all states. Latency 1, never stalled.
- Beat: a_left_vld & b_up_vld in the same cycle. Lane i products are a[i]*b[i], sign- or zero-extended per sgn_left. The lane sum is extended to ACC_W. acc[ptr] <= acc[ptr] + sum, two's-complement wrap. Result visible in acc the next cycle.
- IDLE: load_ready=1.
  - load_vld: write acc[0], ptr=1, go to LOAD.
  - start: clear all acc, ptr=0, go to COMPUTE.
  - load_vld and start together: load wins; err is set.
- LOAD: load_ready=1. Each load_vld writes acc[ptr], ptr++. The beat that writes entry DEPTH-1 wraps ptr to 0 and enters COMPUTE.
- COMPUTE: each beat accumulates into acc[ptr], then ptr++ modulo DEPTH.
  - drain: go to DRAIN, ptr=0. A beat in the same cycle as drain is accumulated first, at its ptr, before ptr resets.
- DRAIN: out_valid=1, out_data=acc[ptr], out_last=(ptr==DEPTH-1).
  - out_data is held stable while out_ready=0.
  - On out_valid & out_ready: ptr++. On the last beat go to IDLE with ptr=0.
- Protocol errors set err (sticky until reset):
  - a beat outside COMPUTE (forwarded, not accumulated);
  - mode 11 on a beat (no accumulate, ptr still advances);
  - start outside IDLE, or drain outside COMPUTE (both ignored);
  - load_vld while load_ready=0 (ignored).
- Reset mid-DRAIN or mid-COMPUTE aborts immediately: contents are lost and out_valid drops asynchronously.

Optional Feature:
- Macro PE_ACC_SAT_EN.
- Defined: accumulation saturates at the signed ACC_W max/min when sgn_left=1, and at the unsigned max when sgn_left=0. An extra output sat_flag (1 bit) goes sticky high on any clamp and is cleared by start or reset.
- Undefined: plain wrap-around; no sat_flag port.

Test Plan:
1. Forwarding: reset, then a_left=0xDEADBEEF with vld=1 for one cycle -> a_right=0xDEADBEEF and a_right_vld=1 exactly one cycle later; b path likewise.
2. INT8 signed dot product:
   - Stimulus: start; then a=0x01FF0203, b=0x02020202, sgn=1, four beats; then drain.
   - Each beat sums 2-2+4+6=10.
   - Response: DRAIN outputs 10, 10, 10, 10; out_last on beat 4; state returns to IDLE.
3. Preload and wrap: load 100, 200, 300, 400; six INT16 beats with a=0x00030002, b=0x00040005 (each +22); drain -> 144, 244, 322, 422.
4. Writeback backpressure: out_ready=0 for 5 cycles in DRAIN -> out_data stable, ptr unchanged; then ready=1 -> DEPTH beats on consecutive cycles.
5. Errors: mode 11 beat in COMPUTE, and a beat in IDLE -> err=1, accumulators unchanged; asserting rst low mid-DRAIN clears out_valid and err immediately.
6. PE_ACC_SAT_EN: preload 0x7FFFFFF0, then an INT16 beat with +0x4000 -> 0x7FFFFFFF and sat_flag=1; without the macro -> 0x80003FF0.
